// File: rtl/axi_lite_master_pkg.sv
// Shared AXI4-Lite response codes and the initiator FSM state type.
package axi_lite_master_pkg;

  localparam logic [1:0] Axi_RespOkay_Con   = 2'b00;
  localparam logic [1:0] Axi_RespExOkay_Con = 2'b01;
  localparam logic [1:0] Axi_RespSlvErr_Con = 2'b10;
  localparam logic [1:0] Axi_RespDecErr_Con = 2'b11;

  localparam logic [2:0] Axi_ProtDefault_Con = 3'b000;

  typedef enum logic [2:0] {
    Idle_St,
    WrAddrData_St,
    WrResp_St,
    RdAddr_St,
    RdData_St,
    Resp_St
  } Axi_MasterState_Type;

  localparam Axi_MasterState_Type Axi_MasterStateReset_Con = Idle_St;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out,
// response/read data back to the issuer, with a per-transaction abort timeout.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int unsigned TimeoutCycles_Gen = 1024,
  parameter int unsigned AddrWidth_Gen     = 32
) (
  input  logic                     SysClk_ClkIn,
  input  logic                     SysRstN_RstIn,
  input  logic                     CmdValid_ValIn,
  output logic                     CmdReady_RdyOut,
  input  logic                     CmdWrite_EnaIn,
  input  logic [AddrWidth_Gen-1:0] CmdAddr_AdrIn,
  input  logic [31:0]              CmdData_DatIn,
  input  logic [3:0]               CmdStrobe_DatIn,
  output logic                     RspValid_ValOut,
  input  logic                     RspReady_RdyIn,
  output logic [1:0]               RspResponse_DatOut,
  output logic [31:0]              RspData_DatOut,
  output logic                     RspTimeout_ValOut,
  output logic                     AxiWriteAddrValid_ValOut,
  input  logic                     AxiWriteAddrReady_RdyIn,
  output logic [AddrWidth_Gen-1:0] AxiWriteAddrAddress_AdrOut,
  output logic [2:0]               AxiWriteAddrProt_DatOut,
  output logic                     AxiWriteDataValid_ValOut,
  input  logic                     AxiWriteDataReady_RdyIn,
  output logic [31:0]              AxiWriteDataData_DatOut,
  output logic [3:0]               AxiWriteDataStrobe_DatOut,
  input  logic                     AxiWriteRespValid_ValIn,
  output logic                     AxiWriteRespReady_RdyOut,
  input  logic [1:0]               AxiWriteRespResponse_DatIn,
  output logic                     AxiReadAddrValid_ValOut,
  input  logic                     AxiReadAddrReady_RdyIn,
  output logic [AddrWidth_Gen-1:0] AxiReadAddrAddress_AdrOut,
  output logic [2:0]               AxiReadAddrProt_DatOut,
  input  logic                     AxiReadDataValid_ValIn,
  output logic                     AxiReadDataReady_RdyOut,
  input  logic [1:0]               AxiReadDataResponse_DatIn,
  input  logic [31:0]              AxiReadDataData_DatIn
);

  localparam int unsigned CntWidth    = (TimeoutCycles_Gen == 0) ? 1 : $clog2(TimeoutCycles_Gen + 1);
  localparam int unsigned TimeoutLast = (TimeoutCycles_Gen == 0) ? 0 : TimeoutCycles_Gen - 1;
  localparam bit          TimeoutEna  = (TimeoutCycles_Gen != 0);

  Axi_MasterState_Type state, stateNext;

  logic                     cmdReady, cmdReadyNext;
  logic                     awValid, awValidNext;
  logic                     wValid, wValidNext;
  logic                     bReady, bReadyNext;
  logic                     arValid, arValidNext;
  logic                     rReady, rReadyNext;
  logic                     rspValid, rspValidNext;
  logic [1:0]               rspResp, rspRespNext;
  logic [31:0]              rspData, rspDataNext;
  logic                     rspTimeout, rspTimeoutNext;
  logic [AddrWidth_Gen-1:0] awAddr, awAddrNext;
  logic [31:0]              wData, wDataNext;
  logic [3:0]               wStrb, wStrbNext;
  logic [AddrWidth_Gen-1:0] arAddr, arAddrNext;
  logic [CntWidth-1:0]      cnt, cntNext;
  logic                     expire;
  logic                     awDone, wDone;

  // State and all registered outputs.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state      <= Axi_MasterStateReset_Con;
      cmdReady   <= 1'b0;
      awValid    <= 1'b0;
      wValid     <= 1'b0;
      bReady     <= 1'b0;
      arValid    <= 1'b0;
      rReady     <= 1'b0;
      rspValid   <= 1'b0;
      rspResp    <= '0;
      rspData    <= '0;
      rspTimeout <= 1'b0;
      awAddr     <= '0;
      wData      <= '0;
      wStrb      <= '0;
      arAddr     <= '0;
      cnt        <= '0;
    end else begin
      state      <= stateNext;
      cmdReady   <= cmdReadyNext;
      awValid    <= awValidNext;
      wValid     <= wValidNext;
      bReady     <= bReadyNext;
      arValid    <= arValidNext;
      rReady     <= rReadyNext;
      rspValid   <= rspValidNext;
      rspResp    <= rspRespNext;
      rspData    <= rspDataNext;
      rspTimeout <= rspTimeoutNext;
      awAddr     <= awAddrNext;
      wData      <= wDataNext;
      wStrb      <= wStrbNext;
      arAddr     <= arAddrNext;
      cnt        <= cntNext;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext      = state;
    awValidNext    = awValid;
    wValidNext     = wValid;
    arValidNext    = arValid;
    rspValidNext   = rspValid;
    rspRespNext    = rspResp;
    rspDataNext    = rspData;
    rspTimeoutNext = rspTimeout;
    awAddrNext     = awAddr;
    wDataNext      = wData;
    wStrbNext      = wStrb;
    arAddrNext     = arAddr;
    cntNext        = cnt;
    awDone         = !awValid || AxiWriteAddrReady_RdyIn;
    wDone          = !wValid || AxiWriteDataReady_RdyIn;
    // Compare with >= so an expiry masked by a handshake still fires in the next phase.
    expire         = TimeoutEna && (cnt >= CntWidth'(TimeoutLast));

    if (state != Idle_St && state != Resp_St && cnt != CntWidth'(TimeoutCycles_Gen))
      cntNext = cnt + CntWidth'(1);

    case (state)
      Idle_St: begin
        if (CmdValid_ValIn && cmdReady) begin
          rspTimeoutNext = 1'b0;
          cntNext        = '0;
          if (CmdWrite_EnaIn) begin
            stateNext   = WrAddrData_St;
            awValidNext = 1'b1;
            wValidNext  = 1'b1;
            awAddrNext  = CmdAddr_AdrIn;
            wDataNext   = CmdData_DatIn;
            wStrbNext   = CmdStrobe_DatIn;
          end else begin
            stateNext   = RdAddr_St;
            arValidNext = 1'b1;
            arAddrNext  = CmdAddr_AdrIn;
          end
        end
      end
      WrAddrData_St: begin
        if (awValid && AxiWriteAddrReady_RdyIn) awValidNext = 1'b0;
        if (wValid && AxiWriteDataReady_RdyIn)  wValidNext  = 1'b0;
        if (awDone && wDone) stateNext = WrResp_St;
        else if (expire)     stateNext = Resp_St;
      end
      WrResp_St: begin
        if (AxiWriteRespValid_ValIn && bReady) begin
          stateNext    = Resp_St;
          rspValidNext = 1'b1;
          rspRespNext  = AxiWriteRespResponse_DatIn;
          rspDataNext  = '0;
        end else if (expire) begin
          stateNext = Resp_St;
        end
      end
      RdAddr_St: begin
        if (arValid && AxiReadAddrReady_RdyIn) begin
          arValidNext = 1'b0;
          stateNext   = RdData_St;
        end else if (expire) begin
          stateNext = Resp_St;
        end
      end
      RdData_St: begin
        if (AxiReadDataValid_ValIn && rReady) begin
          stateNext    = Resp_St;
          rspValidNext = 1'b1;
          rspRespNext  = AxiReadDataResponse_DatIn;
          rspDataNext  = AxiReadDataData_DatIn;
        end else if (expire) begin
          stateNext = Resp_St;
        end
      end
      Resp_St: begin
        if (rspValid && RspReady_RdyIn) begin
          rspValidNext = 1'b0;
          stateNext    = Idle_St;
        end
      end
      default: stateNext = Axi_MasterStateReset_Con;
    endcase

    // Abort path: any active phase that falls into Resp without a response is a timeout.
    if (state != Idle_St && state != Resp_St && stateNext == Resp_St && !rspValidNext) begin
      awValidNext    = 1'b0;
      wValidNext     = 1'b0;
      arValidNext    = 1'b0;
      rspValidNext   = 1'b1;
      rspRespNext    = Axi_RespSlvErr_Con;
      rspDataNext    = '0;
      rspTimeoutNext = 1'b1;
    end

    cmdReadyNext = (stateNext == Idle_St);
    bReadyNext   = (stateNext == WrResp_St);
    rReadyNext   = (stateNext == RdData_St);
  end

  assign CmdReady_RdyOut            = cmdReady;
  assign RspValid_ValOut            = rspValid;
  assign RspResponse_DatOut         = rspResp;
  assign RspData_DatOut             = rspData;
  assign RspTimeout_ValOut          = rspTimeout;
  assign AxiWriteAddrValid_ValOut   = awValid;
  assign AxiWriteAddrAddress_AdrOut = awAddr;
  assign AxiWriteAddrProt_DatOut    = Axi_ProtDefault_Con;
  assign AxiWriteDataValid_ValOut   = wValid;
  assign AxiWriteDataData_DatOut    = wData;
  assign AxiWriteDataStrobe_DatOut  = wStrb;
  assign AxiWriteRespReady_RdyOut   = bReady;
  assign AxiReadAddrValid_ValOut    = arValid;
  assign AxiReadAddrAddress_AdrOut  = arAddr;
  assign AxiReadAddrProt_DatOut     = Axi_ProtDefault_Con;
  assign AxiReadDataReady_RdyOut    = rReady;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: writes, reads, error responses, timeout and async reset.
module tb_axi_lite_master;

  logic        sysClk = 1'b0;
  logic        sysRstN = 1'b0;
  logic        cmdValid = 1'b0, cmdReady, cmdWrite = 1'b0;
  logic [31:0] cmdAddr = '0, cmdData = '0;
  logic [3:0]  cmdStrobe = '0;
  logic        rspValid, rspReady = 1'b0, rspTimeout;
  logic [1:0]  rspResp;
  logic [31:0] rspData;
  logic        awValid, awReady = 1'b0;
  logic [31:0] awAddr;
  logic [2:0]  awProt, arProt;
  logic        wValid, wReady = 1'b0;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        bValid = 1'b0, bReady;
  logic [1:0]  bResp = '0;
  logic        arValid, arReady = 1'b0;
  logic [31:0] arAddr;
  logic        rValid = 1'b0, rReady;
  logic [1:0]  rResp = '0;
  logic [31:0] rData = '0;

  int cmpCnt = 0;
  int errCnt = 0;

  always #5 sysClk = ~sysClk;

  axi_lite_master #(.TimeoutCycles_Gen(16), .AddrWidth_Gen(32)) dut (
    .SysClk_ClkIn(sysClk), .SysRstN_RstIn(sysRstN),
    .CmdValid_ValIn(cmdValid), .CmdReady_RdyOut(cmdReady), .CmdWrite_EnaIn(cmdWrite),
    .CmdAddr_AdrIn(cmdAddr), .CmdData_DatIn(cmdData), .CmdStrobe_DatIn(cmdStrobe),
    .RspValid_ValOut(rspValid), .RspReady_RdyIn(rspReady), .RspResponse_DatOut(rspResp),
    .RspData_DatOut(rspData), .RspTimeout_ValOut(rspTimeout),
    .AxiWriteAddrValid_ValOut(awValid), .AxiWriteAddrReady_RdyIn(awReady),
    .AxiWriteAddrAddress_AdrOut(awAddr), .AxiWriteAddrProt_DatOut(awProt),
    .AxiWriteDataValid_ValOut(wValid), .AxiWriteDataReady_RdyIn(wReady),
    .AxiWriteDataData_DatOut(wData), .AxiWriteDataStrobe_DatOut(wStrb),
    .AxiWriteRespValid_ValIn(bValid), .AxiWriteRespReady_RdyOut(bReady),
    .AxiWriteRespResponse_DatIn(bResp),
    .AxiReadAddrValid_ValOut(arValid), .AxiReadAddrReady_RdyIn(arReady),
    .AxiReadAddrAddress_AdrOut(arAddr), .AxiReadAddrProt_DatOut(arProt),
    .AxiReadDataValid_ValIn(rValid), .AxiReadDataReady_RdyOut(rReady),
    .AxiReadDataResponse_DatIn(rResp), .AxiReadDataData_DatIn(rData)
  );

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    cmdValid = 1'b1; cmdWrite = wr; cmdAddr = addr; cmdData = data; cmdStrobe = strb;
    step();
    cmdValid = 1'b0;
  endtask

  task automatic test_reset();
    sysRstN = 1'b0;
    step(); step();
    cmpCnt++;
    if ({cmdReady, rspValid, rspResp, rspData, rspTimeout, awValid, awAddr, awProt, wValid,
         wData, wStrb, bReady, arValid, arAddr, arProt, rReady} !== '0) begin
      errCnt++; $display("FAIL reset_outputs got nonzero (cmdReady=%b awValid=%b arValid=%b)",
                         cmdReady, awValid, arValid);
    end
    sysRstN = 1'b1;
    step();
    cmpCnt++;
    if (cmdReady !== 1'b1) begin errCnt++; $display("FAIL reset_cmdready got=%b exp=1", cmdReady); end
  endtask

  task automatic test_write_simple();
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    cmpCnt++;
    if ({cmdReady, awValid, wValid, awAddr, wData, wStrb, awProt} !==
        {1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
      errCnt++; $display("FAIL wr_issue got awv=%b wv=%b aw=%h w=%h s=%h exp 1 1 10 deadbeef f",
                         awValid, wValid, awAddr, wData, wStrb);
    end
    step();
    cmpCnt++;
    if ({awValid, wValid, bReady} !== 3'b110) begin
      errCnt++; $display("FAIL wr_hold got=%b exp=110", {awValid, wValid, bReady});
    end
    awReady = 1'b1; wReady = 1'b1;
    step();
    awReady = 1'b0; wReady = 1'b0;
    cmpCnt++;
    if ({awValid, wValid, bReady} !== 3'b001) begin
      errCnt++; $display("FAIL wr_aw_w_hs got=%b exp=001", {awValid, wValid, bReady});
    end
    bValid = 1'b1; bResp = 2'b00;
    step();
    bValid = 1'b0;
    cmpCnt++;
    if ({bReady, rspValid, rspResp, rspData, rspTimeout} !== {1'b0, 1'b1, 2'b00, 32'h0, 1'b0}) begin
      errCnt++; $display("FAIL wr_rsp got br=%b v=%b r=%b d=%h t=%b exp 0 1 00 0 0",
                         bReady, rspValid, rspResp, rspData, rspTimeout);
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    cmpCnt++;
    if ({rspValid, cmdReady} !== 2'b01) begin
      errCnt++; $display("FAIL wr_done got=%b exp=01", {rspValid, cmdReady});
    end
  endtask

  task automatic test_write_w_first();
    issue(1'b1, 32'h0000_0124, 32'hCAFE_0001, 4'h3);
    wReady = 1'b1;
    step();
    wReady = 1'b0;
    cmpCnt++;
    if ({awValid, wValid, bReady} !== 3'b100) begin
      errCnt++; $display("FAIL wfirst_w_hs got=%b exp=100", {awValid, wValid, bReady});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      cmpCnt++;
      if ({awValid, wValid, awAddr} !== {1'b1, 1'b0, 32'h0000_0124}) begin
        errCnt++; $display("FAIL wfirst_aw_hold[%0d] got v=%b wv=%b a=%h exp 1 0 124",
                           i, awValid, wValid, awAddr);
      end
    end
    awReady = 1'b1;
    step();
    awReady = 1'b0;
    cmpCnt++;
    if ({awValid, wValid, bReady} !== 3'b001) begin
      errCnt++; $display("FAIL wfirst_aw_hs got=%b exp=001", {awValid, wValid, bReady});
    end
    bValid = 1'b1; bResp = 2'b00;
    step();
    cmpCnt++;
    if ({rspValid, rspResp, bReady} !== 4'b1000) begin
      errCnt++; $display("FAIL wfirst_rsp got=%b exp=1000", {rspValid, rspResp, bReady});
    end
    step();
    bValid = 1'b0;
    cmpCnt++;
    if ({bReady, rspValid} !== 2'b01) begin
      errCnt++; $display("FAIL wfirst_single_b got=%b exp=01", {bReady, rspValid});
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    cmpCnt++;
    if ({cmdReady, rspValid} !== 2'b10) begin
      errCnt++; $display("FAIL wfirst_idle got=%b exp=10", {cmdReady, rspValid});
    end
  endtask

  task automatic test_read_stall();
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    cmpCnt++;
    if ({arValid, arAddr, arProt, awValid, wValid} !== {1'b1, 32'h0, 3'b000, 1'b0, 1'b0}) begin
      errCnt++; $display("FAIL rd_issue got arv=%b a=%h awv=%b exp 1 0 0", arValid, arAddr, awValid);
    end
    arReady = 1'b1;
    step();
    arReady = 1'b0;
    cmpCnt++;
    if ({arValid, rReady} !== 2'b01) begin
      errCnt++; $display("FAIL rd_ar_hs got=%b exp=01", {arValid, rReady});
    end
    step(); step(); step(); step();
    rValid = 1'b1; rData = 32'h0001_0002; rResp = 2'b00;
    step();
    rValid = 1'b0; rData = 32'hFFFF_FFFF;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 32'h44;
    cmpCnt++;
    if ({rReady, rspValid, rspResp, rspData, rspTimeout} !== {1'b0, 1'b1, 2'b00, 32'h0001_0002, 1'b0}) begin
      errCnt++; $display("FAIL rd_rsp got rr=%b v=%b r=%b d=%h t=%b exp 0 1 00 00010002 0",
                         rReady, rspValid, rspResp, rspData, rspTimeout);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      cmpCnt++;
      if ({rspValid, rspData, cmdReady, awValid} !== {1'b1, 32'h0001_0002, 1'b0, 1'b0}) begin
        errCnt++; $display("FAIL rd_rsp_stall[%0d] got v=%b d=%h cr=%b awv=%b exp 1 00010002 0 0",
                           i, rspValid, rspData, cmdReady, awValid);
      end
    end
    cmdValid = 1'b0;
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    cmpCnt++;
    if ({rspValid, cmdReady, awValid} !== 3'b010) begin
      errCnt++; $display("FAIL rd_done got=%b exp=010", {rspValid, cmdReady, awValid});
    end
  endtask

  task automatic test_read_decerr();
    issue(1'b0, 32'hFFFF_0000, 32'h0, 4'h0);
    arReady = 1'b1;
    step();
    arReady = 1'b0;
    rValid = 1'b1; rResp = 2'b11; rData = 32'h0;
    step();
    rValid = 1'b0; rResp = 2'b00;
    cmpCnt++;
    if ({rspValid, rspResp, rspTimeout} !== 4'b1110) begin
      errCnt++; $display("FAIL rd_decerr got=%b exp=1110", {rspValid, rspResp, rspTimeout});
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
  endtask

  task automatic test_timeout();
    issue(1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 15; i++) begin
      step();
      cmpCnt++;
      if ({awValid, wValid, rspValid} !== 3'b110) begin
        errCnt++; $display("FAIL to_hold[%0d] got=%b exp=110", i, {awValid, wValid, rspValid});
      end
    end
    step();
    cmpCnt++;
    if ({awValid, wValid, bReady, rspValid, rspResp, rspData, rspTimeout} !==
        {3'b000, 1'b1, 2'b10, 32'h0, 1'b1}) begin
      errCnt++; $display("FAIL to_abort got awv=%b wv=%b br=%b v=%b r=%b d=%h t=%b exp 0 0 0 1 10 0 1",
                         awValid, wValid, bReady, rspValid, rspResp, rspData, rspTimeout);
    end
    bValid = 1'b1; bResp = 2'b00;
    step();
    cmpCnt++;
    if ({bReady, rspValid, rspResp} !== 4'b0110) begin
      errCnt++; $display("FAIL to_late_b got=%b exp=0110", {bReady, rspValid, rspResp});
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    cmpCnt++;
    if ({cmdReady, rspValid, rspTimeout, bReady} !== 4'b1010) begin
      errCnt++; $display("FAIL to_idle got=%b exp=1010", {cmdReady, rspValid, rspTimeout, bReady});
    end
    issue(1'b0, 32'h0000_0300, 32'h0, 4'h0);
    cmpCnt++;
    if ({arValid, arAddr, rspTimeout, bReady} !== {1'b1, 32'h0000_0300, 1'b0, 1'b0}) begin
      errCnt++; $display("FAIL to_next_cmd got arv=%b a=%h t=%b br=%b exp 1 300 0 0",
                         arValid, arAddr, rspTimeout, bReady);
    end
    arReady = 1'b1;
    step();
    arReady = 1'b0;
    rValid = 1'b1; rData = 32'h1234_5678; rResp = 2'b01;
    step();
    rValid = 1'b0;
    bValid = 1'b0;
    cmpCnt++;
    if ({rspValid, rspResp, rspData, rspTimeout} !== {1'b1, 2'b01, 32'h1234_5678, 1'b0}) begin
      errCnt++; $display("FAIL to_next_rsp got v=%b r=%b d=%h t=%b exp 1 01 12345678 0",
                         rspValid, rspResp, rspData, rspTimeout);
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
  endtask

  task automatic test_expiry_race();
    issue(1'b0, 32'h0000_0400, 32'h0, 4'h0);
    for (int i = 0; i < 15; i++) step();
    cmpCnt++;
    if ({arValid, rspValid} !== 2'b10) begin
      errCnt++; $display("FAIL race_pre got=%b exp=10", {arValid, rspValid});
    end
    arReady = 1'b1;
    step();
    arReady = 1'b0;
    cmpCnt++;
    if ({arValid, rReady, rspValid, rspTimeout} !== 4'b0100) begin
      errCnt++; $display("FAIL race_ar_wins got=%b exp=0100", {arValid, rReady, rspValid, rspTimeout});
    end
    rValid = 1'b1; rData = 32'h0BAD_F00D; rResp = 2'b00;
    step();
    rValid = 1'b0;
    cmpCnt++;
    if ({rspValid, rspResp, rspData, rspTimeout} !== {1'b1, 2'b00, 32'h0BAD_F00D, 1'b0}) begin
      errCnt++; $display("FAIL race_r_wins got v=%b r=%b d=%h t=%b exp 1 00 0badf00d 0",
                         rspValid, rspResp, rspData, rspTimeout);
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
  endtask

  task automatic test_async_reset();
    issue(1'b0, 32'h0000_0500, 32'h0, 4'h0);
    cmpCnt++;
    if (arValid !== 1'b1) begin errCnt++; $display("FAIL arst_pre got=%b exp=1", arValid); end
    #2 sysRstN = 1'b0;
    #1;
    cmpCnt++;
    if ({cmdReady, rspValid, rspResp, rspData, rspTimeout, awValid, awAddr, wValid,
         wData, wStrb, bReady, arValid, arAddr, rReady} !== '0) begin
      errCnt++; $display("FAIL arst_outputs got arv=%b ara=%h cr=%b exp all 0", arValid, arAddr, cmdReady);
    end
    step();
    sysRstN = 1'b1;
    step();
    cmpCnt++;
    if ({cmdReady, arValid} !== 2'b10) begin
      errCnt++; $display("FAIL arst_release got=%b exp=10", {cmdReady, arValid});
    end
    issue(1'b0, 32'h0000_0600, 32'h0, 4'h0);
    arReady = 1'b1;
    step();
    arReady = 1'b0;
    rValid = 1'b1; rData = 32'hA5A5_0600; rResp = 2'b00;
    step();
    rValid = 1'b0;
    cmpCnt++;
    if ({rspValid, rspResp, rspData} !== {1'b1, 2'b00, 32'hA5A5_0600}) begin
      errCnt++; $display("FAIL arst_fresh_rd got v=%b r=%b d=%h exp 1 00 a5a50600",
                         rspValid, rspResp, rspData);
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_simple();
    test_write_w_first();
    test_read_stall();
    test_read_decerr();
    test_timeout();
    test_expiry_race();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
